// File: rtl/nn_pkg.sv
// Shared definitions for the layer controllers: word width, counter width
// helper and the collector FSM state encoding.
package nn_pkg;

  localparam int BIT_WIDTH_DEF  = 32;
  localparam int EXTRA_BITS_DEF = 2;
  localparam int WORD_W         = BIT_WIDTH_DEF + EXTRA_BITS_DEF;

  // Full word width: floating-point bits plus FloPoCo exception bits.
  function automatic int word_width(input int bit_width, input int extra_bits);
    return bit_width + extra_bits;
  endfunction

  // Counter width able to hold 0..n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/serial_collector_if.sv
// Bus between the upstream intermediate buffer / downstream consumer and the
// serial collector.
//
// Handshake: out_valid is raised by the collector when a whole frame is
// assembled and stays high, with parallel_out/error_out/net_derivative_out
// frozen, until a cycle in which out_valid and out_ready are both 1; that
// cycle is the transfer. out_ready may be driven independently of out_valid.
// start is a one-cycle pulse coincident with the upstream capture enable.
interface serial_collector_if #(
  parameter int NUM_NEURONS = 4,
  parameter int NUM_NONLIN  = 1,
  parameter int W           = 34
);
  logic                      start;
  logic [W-1:0]              serial_in;
  logic [W-1:0]              error_in;
  logic [NUM_NONLIN*W-1:0]   net_derivative_in;
  logic                      out_ready;
  logic                      out_valid;
  logic [NUM_NEURONS*W-1:0]  parallel_out;
  logic [W-1:0]              error_out;
  logic [NUM_NONLIN*W-1:0]   net_derivative_out;
  logic                      busy;
  logic                      overrun;

  modport master (
    output start, serial_in, error_in, net_derivative_in, out_ready,
    input  out_valid, parallel_out, error_out, net_derivative_out, busy, overrun
  );

  modport slave (
    input  start, serial_in, error_in, net_derivative_in, out_ready,
    output out_valid, parallel_out, error_out, net_derivative_out, busy, overrun
  );
endinterface

// File: rtl/serial_collector_slot_counter.sv
// slot_counter: clear/enable up-counter over 0..LIMIT-1 with a terminal-count
// flag. Wraps to 0 after the terminal value so it never exceeds LIMIT-1.
module slot_counter
  import nn_pkg::*;
#(
  parameter int LIMIT = 4,
  parameter int CW    = cnt_width(LIMIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          terminal
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign terminal = (count_q == CW'(LIMIT - 1));
  assign count    = count_q;

  // Next count: clear wins over enable; wrap at the terminal value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = terminal ? '0 : count_q + CW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_collector.sv
// serial_collector: reassembles NUM_NEURONS serial words (lowest slot first)
// into one parallel frame, latching the error word and net derivatives
// alongside, and offers the frame to a consumer with valid/ready.
// Optional feature: define SERIAL_COLLECTOR_OVERRUN_EN to get a sticky
// overrun flag for starts that arrive while a frame is still in flight;
// otherwise overrun is tied to 0.
module serial_collector
  import nn_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int NUM_NONLIN  = 1,
  parameter int BIT_WIDTH   = 32,
  parameter int EXTRA_BITS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  serial_collector_if.slave   bus,
  output state_t              dbg_state
);

  localparam int W  = word_width(BIT_WIDTH, EXTRA_BITS);
  localparam int CW = cnt_width(NUM_NEURONS);

  state_t                       state_q, state_d;
  logic [NUM_NEURONS*W-1:0]     slots_q, slots_d;
  logic [W-1:0]                 err_q, err_d;
  logic [NUM_NONLIN*W-1:0]      nd_q, nd_d;
  logic                         valid_q, valid_d;
  logic                         busy_q, busy_d;

  logic                         cnt_clear;
  logic                         cnt_en;
  logic [CW-1:0]                cnt;
  logic                         cnt_tc;
  logic                         xfer;
  logic                         accept_start;

  // A start is only honoured when the collector is free: idle, or handing
  // its frame over in this very cycle.
  assign xfer         = (state_q == HOLD) && bus.out_ready;
  assign accept_start = bus.start && ((state_q == IDLE) || xfer);

  slot_counter #(
    .LIMIT (NUM_NEURONS),
    .CW    (CW)
  ) u_slot_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .count    (cnt),
    .terminal (cnt_tc)
  );

  // Next-state and datapath: slot writes, side-data latch and handshake.
  always_comb begin
    state_d   = state_q;
    slots_d   = slots_q;
    err_d     = err_q;
    nd_d      = nd_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_start) begin
          state_d   = CAPTURE;
          cnt_clear = 1'b1;
        end
      end
      CAPTURE: begin
        cnt_en = 1'b1;
        for (int k = 0; k < NUM_NEURONS; k++) begin
          if (cnt == CW'(k)) begin
            slots_d[k*W +: W] = bus.serial_in;
          end
        end
        // Side data belongs to the frame; take it on the first slot write.
        if (cnt == '0) begin
          err_d = bus.error_in;
          nd_d  = bus.net_derivative_in;
        end
        if (cnt_tc) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (xfer) begin
          if (accept_start) begin
            state_d   = CAPTURE;
            cnt_clear = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    valid_d = (state_d == HOLD);
    busy_d  = (state_d != IDLE);
  end

  // FSM state and registered outputs; reset clears the frame completely.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      slots_q <= '0;
      err_q   <= '0;
      nd_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slots_q <= slots_d;
      err_q   <= err_d;
      nd_q    <= nd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SERIAL_COLLECTOR_OVERRUN_EN
  logic overrun_q, overrun_d;
  logic drop_start;

  assign drop_start = bus.start && !accept_start;

  // Sticky record of any start that arrived while a frame was in flight.
  always_comb begin
    overrun_d = overrun_q | drop_start;
  end

  // Overrun register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign bus.overrun = overrun_q;
`else
  assign bus.overrun = 1'b0;
`endif

  assign bus.out_valid          = valid_q;
  assign bus.busy               = busy_q;
  assign bus.parallel_out       = slots_q;
  assign bus.error_out          = err_q;
  assign bus.net_derivative_out = nd_q;
  assign dbg_state              = state_q;

endmodule

// File: tb/tb_serial_collector.sv
// Bench for serial_collector (NUM_NEURONS=4, 34-bit words, one net derivative).
module tb_serial_collector;
  import nn_pkg::*;

  localparam int N  = 4;
  localparam int NL = 1;
  localparam int BW = 32;
  localparam int EB = 2;
  localparam int W  = BW + EB;
  localparam int FW = N*W + W + NL*W;

`ifdef SERIAL_COLLECTOR_OVERRUN_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  always #5 clk = ~clk;

  serial_collector_if #(.NUM_NEURONS(N), .NUM_NONLIN(NL), .W(W)) bus ();

  serial_collector #(
    .NUM_NEURONS (N),
    .NUM_NONLIN  (NL),
    .BIT_WIDTH   (BW),
    .EXTRA_BITS  (EB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  logic [FW-1:0] exp_q[$];

  typedef struct {
    logic [N*W-1:0]  par;
    logic [W-1:0]    err;
    logic [NL*W-1:0] nd;
    int              hold;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  function automatic logic [NL*W-1:0] rand_nd();
    logic [NL*W-1:0] v;
    for (int k = 0; k < NL; k++) v[k*W +: W] = rand_word();
    return v;
  endfunction

  function automatic logic [N*W-1:0] pack4(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c, input logic [W-1:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [N*W-1:0] rand_par();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = rand_word();
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got frame %0h expected none", bus.parallel_out);
      end else begin
        check("sb_frame", {bus.parallel_out, bus.error_out, bus.net_derivative_out},
              exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // Drives one frame starting next cycle (cycle 0 = start). Side data is only
  // valid in cycle 1; other cycles carry random junk on those inputs.
  task automatic run_frame(input logic [N*W-1:0] par, input logic [W-1:0] err,
                           input logic [NL*W-1:0] nd, input int hold,
                           input bit b2b, input bit leave_pending, input int dup_start);
    logic [FW-1:0] snap;
    logic          rdy;
    int            lat;
    bit            found;
    rdy = (hold == 0) && !leave_pending;
    tick();
    bus.start             = 1'b1;
    bus.out_ready         = b2b ? 1'b1 : rdy;
    bus.serial_in         = rand_word();
    bus.error_in          = rand_word();
    bus.net_derivative_in = rand_nd();
    for (int k = 0; k < N; k++) begin
      tick();
      bus.start     = (k + 1 == dup_start);
      bus.out_ready = rdy;
      bus.serial_in = par[k*W +: W];
      if (k == 0) begin
        bus.error_in          = err;
        bus.net_derivative_in = nd;
        exp_q.push_back({par, err, nd});
      end else begin
        bus.error_in          = rand_word();
        bus.net_derivative_in = rand_nd();
      end
      if (k == 0 && b2b) begin
        @(negedge clk);
        check("b2b_busy", bus.busy, 1);
        check("b2b_valid_low", bus.out_valid, 0);
      end
    end
    found = 1'b0;
    lat   = N;
    while (!found && lat < N + 12) begin
      tick();
      bus.start     = 1'b0;
      bus.serial_in = rand_word();
      lat++;
      @(negedge clk);
      found = bus.out_valid;
    end
    check("valid_latency", lat, N + 1);
    check("valid_busy", bus.busy, 1);
    if (hold > 0) begin
      snap = {bus.parallel_out, bus.error_out, bus.net_derivative_out};
      for (int i = 0; i < hold; i++) begin
        tick();
        bus.serial_in         = rand_word();
        bus.error_in          = rand_word();
        bus.net_derivative_in = rand_nd();
        @(negedge clk);
        check("bp_valid", bus.out_valid, 1);
        check("bp_busy", bus.busy, 1);
        check("bp_stable", {bus.parallel_out, bus.error_out, bus.net_derivative_out}, snap);
      end
    end
    if (!leave_pending) begin
      if (!rdy) begin
        tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
      end
      tick();
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("post_xfer_valid", bus.out_valid, 0);
      check("post_xfer_busy", bus.busy, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_overrun"}, bus.overrun, 0);
    check({tag, "_par"}, bus.parallel_out, 0);
    check({tag, "_err"}, bus.error_out, 0);
    check({tag, "_nd"}, bus.net_derivative_out, 0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    bit pend;
    bit lp;

    vecs[0] = '{pack4(34'd1, 34'd2, 34'd3, 34'd4), 34'h0_DEAD_BEEF, 34'h1_2345_6789, 0};
    vecs[1] = '{pack4(34'h2_0000_0011, 34'h3_8000_0022, 34'h1_7F80_0033, 34'h0_0000_0044),
                34'h3_C000_0000, 34'h2_0000_0001, 10};
    vecs[2] = '{pack4(34'h3_FFFF_FFFF, 34'h0_0000_0000, 34'h1_5555_5555, 34'h2_AAAA_AAAA),
                34'h1_AAAA_5555, 34'h3_FFFF_FFFF, 3};
    vecs[3] = '{rand_par(), rand_word(), rand_nd(), 1};

    // Reset, with start/out_ready asserted to show reset priority.
    rst                   = 1'b1;
    bus.start             = 1'b0;
    bus.serial_in         = '0;
    bus.error_in          = '0;
    bus.net_derivative_in = '0;
    bus.out_ready         = 1'b0;
    tick();
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    bus.serial_in = rand_word();
    tick();
    tick();
    @(negedge clk);
    check_all_zero("rst");
    tick();
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;

    // Table of single frames: basic, backpressure and bit patterns.
    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i].par, vecs[i].err, vecs[i].nd, vecs[i].hold, 1'b0, 1'b0, -1);
    end

    // Back-to-back: second start coincides with the first transfer.
    run_frame(pack4(34'd1, 34'd2, 34'd3, 34'd4), 34'h0_1111_1111, 34'h0_2222_2222, 0, 1'b0, 1'b1, -1);
    run_frame(pack4(34'd5, 34'd6, 34'd7, 34'd8), 34'h0_3333_3333, 34'h0_4444_4444, 0, 1'b1, 1'b0, -1);
    check("b2b_no_overrun", bus.overrun, 0);

    // Dropped start in cycle 2 must not disturb the frame.
    run_frame(pack4(34'd1, 34'd2, 34'd3, 34'd4), 34'h2_5A5A_5A5A, 34'h1_0F0F_0F0F, 0, 1'b0, 1'b0, 2);
    check("overrun_set", bus.overrun, EXP_OVR);
    run_frame(rand_par(), rand_word(), rand_nd(), 0, 1'b0, 1'b0, -1);
    check("overrun_sticky", bus.overrun, EXP_OVR);

    // Reset in cycle 3 of a frame, fresh start in cycle 6.
    tick();
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    bus.serial_in = rand_word();
    tick();
    bus.start     = 1'b0;
    bus.serial_in = 34'd1;
    bus.error_in  = rand_word();
    tick();
    bus.serial_in = 34'd2;
    tick();
    rst           = 1'b1;
    bus.start     = 1'b1;
    bus.serial_in = 34'd3;
    tick();
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.serial_in = 34'd4;
    @(negedge clk);
    check_all_zero("midrst");
    tick();
    run_frame(pack4(34'd9, 34'd10, 34'd11, 34'd12), 34'h1_CAFE_F00D, 34'h2_BEEF_0001, 0, 1'b0, 1'b0, -1);

    // Random round-trip frames with random backpressure and chaining.
    pend = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      lp = ($urandom_range(0, 3) == 0) && (i < 999);
      run_frame(rand_par(), rand_word(), rand_nd(), $urandom_range(0, 3), pend, lp, -1);
      pend = lp;
    end

    check("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_collector.md
SERIAL_COLLECTOR -- requirements
Module: serial_collector

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 4: number of serial words per frame (≥1).
REQ-002 SHALL have parameter NUM_NONLIN, default 1: number of net-derivative words carried alongside each frame.
REQ-003 SHALL have parameter BIT_WIDTH, default 32: floating-point word size.
REQ-004 SHALL have parameter EXTRA_BITS, default 2: FloPoCo exception bits, legal values 0 or 2 only; word width W = BIT_WIDTH+EXTRA_BITS.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1: frame start, asserted in the same cycle as the upstream buffer's capture enable.
REQ-008 SHALL have port serial_in, input, W: serialized word, lowest slot first.
REQ-009 SHALL have port error_in, input, W: error word from the upstream buffer.
REQ-010 SHALL have port net_derivative_in, input, NUM_NONLIN*W: net derivatives from the upstream buffer.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the frame.
REQ-012 SHALL have port out_valid, output, 1: assembled frame available.
REQ-013 SHALL have port parallel_out, output, NUM_NEURONS*W: reassembled frame, with slot k at bits [k*W +: W].
REQ-014 SHALL have port error_out, output, W: error word latched with the frame.
REQ-015 SHALL have port net_derivative_out, output, NUM_NONLIN*W: net derivatives latched with the frame.
REQ-016 SHALL have port busy, output, 1: high in CAPTURE or HOLD.
REQ-017 SHALL have port overrun, output, 1: sticky flag for a dropped start.

Function
REQ-018 SHALL implement FSM states IDLE, CAPTURE and HOLD.
REQ-019 SHALL transition IDLE→CAPTURE on start=1 and clear the slot counter to 0.
REQ-020 SHALL, in CAPTURE, write serial_in into slot[counter] each cycle and increment the counter, so that the word present k+1 cycles after start lands in slot k.
REQ-021 SHALL latch error_in and net_derivative_in in the first CAPTURE cycle (one cycle after start).
REQ-022 SHALL transition CAPTURE→HOLD on the cycle that writes slot NUM_NEURONS-1; out_valid rises NUM_NEURONS+1 cycles after start.
REQ-023 SHALL hold parallel_out, error_out and net_derivative_out stable while out_valid=1 and out_ready=0.
REQ-024 SHALL treat a cycle with out_valid=1 and out_ready=1 as the transfer, transitioning HOLD→IDLE, or HOLD→CAPTURE if start=1 in that same cycle (back-to-back frames with no bubble).
REQ-025 SHALL ignore start in CAPTURE, or in HOLD without out_ready, leaving frame data unchanged and setting overrun (see REQ-030).
REQ-026 SHALL keep the slot counter at ceil(log2(NUM_NEURONS+1)) bits, never exceeding NUM_NEURONS-1 while writing; with NUM_NEURONS=1, CAPTURE lasts one cycle.
REQ-027 SHALL pass data through bit-exact, performing no arithmetic on words.

Reset
REQ-028 SHALL, while rst=1, force state=IDLE, counter=0, out_valid=0, busy=0, overrun=0, and parallel_out, error_out and net_derivative_out all to zero; rst has priority over start and out_ready.
REQ-029 SHALL, when reset is asserted mid-CAPTURE or in HOLD, discard the partial frame and accept the first start after rst deasserts as a fresh frame.

Configuration
REQ-030 SHALL, with SERIAL_COLLECTOR_OVERRUN_EN defined, implement overrun as a sticky flag set by a dropped start and cleared only by rst.
REQ-031 SHALL, without SERIAL_COLLECTOR_OVERRUN_EN, keep the overrun port present and tied to 0, contain no overrun logic, and leave dropped-start behaviour otherwise identical.

Structure
REQ-032 SHALL place WORD_W, the clog2-based counter width function and the FSM state encoding in the shared package nn_pkg.
REQ-033 SHALL use one sub-module, slot_counter: a parameterised clear/enable counter with terminal-count output, reusable by other layer controllers.

Verification (NUM_NEURONS=4, BIT_WIDTH=32, EXTRA_BITS=2, NUM_NONLIN=1)
REQ-034 SHALL cover a basic frame: start at cycle 0, serial_in = 1,2,3,4 in cycles 1–4, out_ready=1 → out_valid=1 at cycle 5, parallel_out slots {0..3} = {1,2,3,4}, error_out equal to error_in sampled at cycle 1.
REQ-035 SHALL cover backpressure: out_ready=0 for 10 cycles after out_valid → outputs constant, busy=1; out_ready=1 → out_valid=0 next cycle.
REQ-036 SHALL cover back-to-back frames: start coincident with the transfer cycle, second frame words 5–8 → second out_valid exactly 5 cycles later, slots {5,6,7,8}, no bubble.
REQ-037 SHALL cover overrun: start at cycle 2 mid-CAPTURE → frame 1 unaffected = {1,2,3,4}, overrun=1 with macro defined, 0 without.
REQ-038 SHALL cover reset mid-operation: rst at cycle 3 → all outputs 0 at cycle 4; new start at cycle 6 with words 9–12 → valid at cycle 11, slots {9,10,11,12}.
REQ-039 SHALL cover a round-trip with the upstream intermediate buffer: random layer_output → parallel_out identical bit-for-bit, including exception bits, over 1000 frames.
